// File: rtl/aes_key_schedule.sv
// AES key-expansion engine for AES-128/192/256 (NK = 4/6/8).
// Expands the cipher key one 32-bit word per cycle into an internal word
// array, then serves round keys combinationally in forward or reverse order.
module aes_key_schedule #(
  parameter int NK = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              KEY_START,
  input  logic [32*NK-1:0]  KEY_IN,
  output logic              KEY_BUSY,
  output logic              KEY_DONE,
  output logic              KEY_VALID,
  input  logic              RK_REVERSE,
  input  logic [3:0]        RK_ADDR,
  output logic [127:0]      RK_OUT
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  // Only the three AES key lengths are meaningful.
  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_key_schedule: NK must be 4, 6 or 8");
  end

  // Forward AES S-box; entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_ROM[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t      state;
  logic [5:0]  word_idx;
  logic [2:0]  phase;
  logic [7:0]  rcon;
  logic [31:0] w [NW];

  logic [5:0]  prev_idx;
  logic [5:0]  back_idx;
  logic [31:0] prev_word;
  logic [31:0] back_word;
  logic [31:0] temp_word;
  logic [31:0] next_word;

  logic        in_range;
  logic [3:0]  eff_round;
  logic [5:0]  rd_base;

  // Next schedule word from w[i-1] and w[i-NK]; phase tracks i mod NK.
  always_comb begin
    prev_idx  = word_idx - 6'd1;
    back_idx  = word_idx - 6'(NK);
    prev_word = w[prev_idx];
    back_word = w[back_idx];
    temp_word = prev_word;
    if (phase == 3'd0) begin
      temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
    end else if (NK == 8 && phase == 3'd4) begin
      temp_word = sub_word(prev_word);
    end
    next_word = back_word ^ temp_word;
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      KEY_BUSY  <= 1'b0;
      KEY_DONE  <= 1'b0;
      KEY_VALID <= 1'b0;
      word_idx  <= 6'd0;
      phase     <= 3'd0;
      rcon      <= 8'h01;
    end else begin
      case (state)
        IDLE: begin
          KEY_DONE <= 1'b0;
          if (KEY_START) begin
            word_idx  <= 6'(NK);
            phase     <= 3'd0;
            rcon      <= 8'h01;
            KEY_VALID <= 1'b0;
            KEY_BUSY  <= 1'b1;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          word_idx <= word_idx + 6'd1;
          phase    <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) begin
            rcon <= xtime(rcon);
          end
          if (word_idx == 6'(NW - 1)) begin
            KEY_BUSY  <= 1'b0;
            KEY_DONE  <= 1'b1;
            KEY_VALID <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          KEY_DONE <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Word array: key words loaded on start, one expanded word per EXPAND cycle.
  always_ff @(posedge CLK) begin
    if (state == IDLE && KEY_START) begin
      for (int k = 0; k < NK; k++) begin
        w[k] <= KEY_IN[32*(NK-1-k) +: 32];
      end
    end else if (state == EXPAND) begin
      w[word_idx] <= next_word;
    end
  end

  // Round-key read port; invalid schedule or out-of-range address reads zero.
  always_comb begin
    in_range  = KEY_VALID && (RK_ADDR <= 4'(NR));
    eff_round = RK_REVERSE ? (4'(NR) - RK_ADDR) : RK_ADDR;
    rd_base   = in_range ? {eff_round, 2'b00} : 6'd0;
    RK_OUT    = 128'h0;
    if (in_range) begin
      RK_OUT = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Testbench for aes_key_schedule: one instance per key length, known-answer
// vectors, random keys against a FIPS-197 style model, and control corner cases.
module tb_aes_key_schedule;

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K2 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K6 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    int           nk;
    logic [255:0] key;
    logic         rev;
    logic [3:0]   addr;
    logic [127:0] exp;
  } vec_t;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         start;
  logic         rk_rev;
  logic [3:0]   rk_addr;
  logic [255:0] key_drv;
  int           sel_nk;

  logic         start4, start6, start8;
  logic         busy4, busy6, busy8;
  logic         done4, done6, done8;
  logic         valid4, valid6, valid8;
  logic [127:0] rk4, rk6, rk8;

  logic         sel_busy, sel_done, sel_valid;
  logic [127:0] sel_rk;

  int total_cnt = 0;
  int bad_cnt = 0;

  logic [7:0]  msbox [256];
  logic [31:0] mw [60];
  vec_t        vecs [13];

  always #5 CLK = ~CLK;

  assign start4 = start && (sel_nk == 4);
  assign start6 = start && (sel_nk == 6);
  assign start8 = start && (sel_nk == 8);

  aes_key_schedule #(.NK(4)) dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .KEY_START(start4), .KEY_IN(key_drv[127:0]),
    .KEY_BUSY(busy4), .KEY_DONE(done4), .KEY_VALID(valid4),
    .RK_REVERSE(rk_rev), .RK_ADDR(rk_addr), .RK_OUT(rk4)
  );

  aes_key_schedule #(.NK(6)) dut6 (
    .CLK(CLK), .RESET_N(RESET_N), .KEY_START(start6), .KEY_IN(key_drv[191:0]),
    .KEY_BUSY(busy6), .KEY_DONE(done6), .KEY_VALID(valid6),
    .RK_REVERSE(rk_rev), .RK_ADDR(rk_addr), .RK_OUT(rk6)
  );

  aes_key_schedule #(.NK(8)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .KEY_START(start8), .KEY_IN(key_drv),
    .KEY_BUSY(busy8), .KEY_DONE(done8), .KEY_VALID(valid8),
    .RK_REVERSE(rk_rev), .RK_ADDR(rk_addr), .RK_OUT(rk8)
  );

  // Route the instance under test to a common set of observation signals.
  always_comb begin
    sel_busy  = busy4;
    sel_done  = done4;
    sel_valid = valid4;
    sel_rk    = rk4;
    if (sel_nk == 6) begin
      sel_busy  = busy6;
      sel_done  = done6;
      sel_valid = valid6;
      sel_rk    = rk6;
    end else if (sel_nk == 8) begin
      sel_busy  = busy8;
      sel_done  = done8;
      sel_valid = valid8;
      sel_rk    = rk8;
    end
  end

  task automatic checkOutput(input string name, input int idx,
                             input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // GF(2^8) arithmetic used to derive the S-box from first principles.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      msbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] msubw(input logic [31:0] x);
    return {msbox[x[31:24]], msbox[x[23:16]], msbox[x[15:8]], msbox[x[7:0]]};
  endfunction

  // Reference key expansion following the textbook FIPS-197 loop.
  task automatic build_model(input int nk, input logic [255:0] key);
    int         nw = 4 * (nk + 7);
    logic [7:0] rc = 8'h01;
    logic [31:0] t;
    for (int k = 0; k < nk; k++) mw[k] = key[32*(nk-1-k) +: 32];
    for (int i = nk; i < nw; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = msubw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = msubw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int nk, input logic rev, input int addr);
    int nr = nk + 6;
    int e;
    if (addr > nr) return 128'h0;
    e = rev ? nr - addr : addr;
    return {mw[4*e], mw[4*e+1], mw[4*e+2], mw[4*e+3]};
  endfunction

  // Launch one expansion and check busy length, done timing and pulse shape.
  task automatic applyStimulus(input int nk, input logic [255:0] key,
                               input int extra_at, input logic [255:0] extra_key);
    int busy_cnt = 0;
    int done_cyc = 0;
    int words    = 4 * (nk + 7) - nk;
    @(negedge CLK);
    sel_nk  = nk;
    key_drv = key;
    start   = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
      if (sel_busy) busy_cnt++;
      if (sel_done) done_cyc = c;
      start = (c == extra_at);
      if (c == extra_at) key_drv = extra_key;
      if (done_cyc == 0) @(negedge CLK);
    end
    start = 1'b0;
    checkOutput("busy_cycles", nk, 128'(busy_cnt), 128'(words));
    checkOutput("done_cycle", nk, 128'(done_cyc), 128'(words + 1));
    checkOutput("busy_at_done", nk, 128'(sel_busy), 128'h0);
    @(negedge CLK);
    checkOutput("done_pulse_end", nk, 128'(sel_done), 128'h0);
    checkOutput("valid_after", nk, 128'(sel_valid), 128'h1);
  endtask

  initial begin
    logic [255:0] cur_key;
    int           cur_nk;
    logic [255:0] rkey;
    int           nks [3];
    int           done_seen;

    RESET_N = 1'b0;
    start   = 1'b0;
    rk_rev  = 1'b0;
    rk_addr = 4'd0;
    key_drv = '0;
    sel_nk  = 4;
    build_sbox();

    vecs[0]  = '{4, K1, 1'b0, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[1]  = '{4, K1, 1'b0, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[2]  = '{4, K1, 1'b0, 4'd11, 128'h0};
    vecs[3]  = '{4, K1, 1'b1, 4'd15, 128'h0};
    vecs[4]  = '{4, K2, 1'b0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[5]  = '{4, K2, 1'b1, 4'd0,  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[6]  = '{4, K2, 1'b1, 4'd10, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[7]  = '{4, K2, 1'b1, 4'd11, 128'h0};
    vecs[8]  = '{6, K6, 1'b0, 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d};
    vecs[9]  = '{6, K6, 1'b1, 4'd12, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[10] = '{8, K8, 1'b0, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[11] = '{8, K8, 1'b1, 4'd14, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[12] = '{8, K8, 1'b0, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};

    // Reset state.
    repeat (3) @(negedge CLK);
    checkOutput("reset_busy", 0, 128'(busy4), 128'h0);
    checkOutput("reset_done", 0, 128'(done4), 128'h0);
    checkOutput("reset_valid", 0, 128'(valid4), 128'h0);
    checkOutput("reset_rk", 0, rk4, 128'h0);
    RESET_N = 1'b1;
    @(negedge CLK);
    checkOutput("idle_rk_invalid", 0, rk8, 128'h0);

    // Known-answer vectors.
    cur_nk  = 0;
    cur_key = '0;
    for (int v = 0; v < 13; v++) begin
      if (vecs[v].nk != cur_nk || vecs[v].key != cur_key) begin
        applyStimulus(vecs[v].nk, vecs[v].key, 0, '0);
        cur_nk  = vecs[v].nk;
        cur_key = vecs[v].key;
      end
      @(negedge CLK);
      sel_nk  = vecs[v].nk;
      rk_rev  = vecs[v].rev;
      rk_addr = vecs[v].addr;
      #1;
      checkOutput("kat", v, sel_rk, vecs[v].exp);
    end

    // Random keys against the reference model, every address both directions.
    nks = '{4, 6, 8};
    for (int n = 0; n < 3; n++) begin
      for (int r = 0; r < 2; r++) begin
        rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        rkey = rkey & ((256'h1 << (32 * nks[n])) - 256'h1);
        build_model(nks[n], rkey);
        applyStimulus(nks[n], rkey, 0, '0);
        for (int a = 0; a < 16; a++) begin
          for (int d = 0; d < 2; d++) begin
            @(negedge CLK);
            rk_addr = 4'(a);
            rk_rev  = d[0];
            #1;
            checkOutput("rand_rk", nks[n] * 100 + a * 2 + d, sel_rk, model_rk(nks[n], d[0], a));
          end
        end
      end
    end

    // Extra start during expansion is ignored; original key's schedule results.
    applyStimulus(4, K1, 10, K2);
    @(negedge CLK);
    rk_rev  = 1'b0;
    rk_addr = 4'd10;
    #1;
    checkOutput("ignored_restart", 0, rk4, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Re-key while valid: valid drops at the start edge.
    @(negedge CLK);
    checkOutput("rekey_pre_valid", 0, 128'(valid4), 128'h1);
    sel_nk  = 4;
    key_drv = K2;
    start   = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("rekey_valid_fall", 0, 128'(valid4), 128'h0);
    checkOutput("rekey_busy", 0, 128'(busy4), 128'h1);
    @(negedge CLK);
    start     = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 100 && done_seen == 0; c++) begin
      if (done4) done_seen = 1;
      @(negedge CLK);
    end
    checkOutput("rekey_done", 0, 128'(done_seen), 128'h1);
    rk_rev  = 1'b0;
    rk_addr = 4'd0;
    #1;
    checkOutput("rekey_rk0", 0, rk4, K2[127:0]);

    // Reset mid-expansion aborts immediately and produces no done.
    @(negedge CLK);
    sel_nk  = 4;
    key_drv = K1;
    start   = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (19) @(negedge CLK);
    checkOutput("abort_pre_busy", 0, 128'(busy4), 128'h1);
    RESET_N = 1'b0;
    #1;
    checkOutput("abort_busy", 0, 128'(busy4), 128'h0);
    checkOutput("abort_done", 0, 128'(done4), 128'h0);
    checkOutput("abort_valid4", 0, 128'(valid4), 128'h0);
    checkOutput("abort_valid6", 0, 128'(valid6), 128'h0);
    checkOutput("abort_valid8", 0, 128'(valid8), 128'h0);
    checkOutput("abort_rk", 0, rk4, 128'h0);
    @(negedge CLK);
    RESET_N   = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (done4 || busy4) done_seen++;
    end
    checkOutput("abort_no_done", 0, 128'(done_seen), 128'h0);
    checkOutput("abort_post_valid", 0, 128'(valid4), 128'h0);
    checkOutput("abort_post_rk", 0, rk4, 128'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
